// File: rtl/io_host_if.sv
// Byte-wide four-phase handshake link between the host driver (master) and its peer (slave).
interface io_host_if;
  logic [1:0] to_hw_sig;
  logic [7:0] to_hw_port;
  logic [1:0] to_sw_sig;
  logic [7:0] to_sw_port;

  modport master (output to_hw_sig, to_hw_port, input to_sw_sig, to_sw_port);
  modport slave  (input to_hw_sig, to_hw_port, output to_sw_sig, to_sw_port);
endinterface

// File: rtl/io_host_driver.sv
// Host-side driver: ships 16 msg + 16 key bytes to a peer, issues GO, reads back 16 result bytes.
// Optional watchdog enabled by defining IO_HOST_TIMEOUT_EN.
module io_host_driver (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [127:0]     msg_in,
  input  logic [127:0]     key_in,
  io_host_if.master        hw,
  output logic [127:0]     msg_out,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [3:0] {
    IDLE, MSG_PUT, MSG_REL, KEY_PUT, KEY_REL, GO, RD_REQ, RD_REL, FIN
  } state_t;

  state_t            state, nxt;
  logic [3:0]        idx;
  logic [15:0][7:0]  msg_q, key_q, res_q;
  logic [1:0]        sw;

  assign sw      = hw.to_sw_sig;
  assign msg_out = res_q;

`ifdef IO_HOST_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        waiting, timeout;

  assign waiting = (state != IDLE) && (state != FIN);
  assign timeout = waiting && (wd_cnt == 16'hFFFF);

  always_ff @(posedge clk or posedge reset)
    if (reset)              wd_cnt <= '0;
    else if (nxt != state)  wd_cnt <= '0;
    else if (waiting)       wd_cnt <= wd_cnt + 16'd1;

  // sticky until a new transaction is accepted
  always_ff @(posedge clk or posedge reset)
    if (reset)                        error <= 1'b0;
    else if (state == IDLE && start)  error <= 1'b0;
    else if (timeout)                 error <= 1'b1;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start)        nxt = MSG_PUT;
      MSG_PUT: if (sw == 2'd1)   nxt = MSG_REL;
      MSG_REL: if (sw == 2'd0)   nxt = (idx == 4'd15) ? KEY_PUT : MSG_PUT;
      KEY_PUT: if (sw == 2'd1)   nxt = KEY_REL;
      KEY_REL: if (sw == 2'd0)   nxt = (idx == 4'd15) ? GO : KEY_PUT;
      GO:      if (sw == 2'd2)   nxt = RD_REQ;
      RD_REQ:  if (sw == 2'd1)   nxt = RD_REL;
      RD_REL:  if (sw == 2'd0)   nxt = (idx == 4'd15) ? FIN : RD_REQ;
      FIN:                       nxt = IDLE;
      default:                   nxt = IDLE;
    endcase
`ifdef IO_HOST_TIMEOUT_EN
    if (timeout) nxt = IDLE;
`endif
  end

  // idx wraps 15->0 on the last msg/key release, which is the reset the next phase needs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx   <= '0;
      msg_q <= '0;
      key_q <= '0;
      res_q <= '0;
    end else begin
      unique case (state)
        IDLE:
          if (start) begin
            msg_q <= msg_in;
            key_q <= key_in;
            idx   <= '0;
          end
        MSG_REL, KEY_REL:
          if (sw == 2'd0) idx <= idx + 4'd1;
        GO:
          if (sw == 2'd2) idx <= '0;
        RD_REQ:
          if (sw == 2'd1) res_q[4'd15 - idx] <= hw.to_sw_port;
        RD_REL:
          if (sw == 2'd0 && idx != 4'd15) idx <= idx + 4'd1;
        default: ;
      endcase
    end

  // decoded from registered state/idx only; the peer's code never reaches these
  always_comb begin
    hw.to_hw_sig  = 2'd0;
    hw.to_hw_port = 8'h00;
    busy          = (state != IDLE);
    done          = 1'b0;
    unique case (state)
      MSG_PUT: begin hw.to_hw_sig = 2'd1; hw.to_hw_port = msg_q[4'd15 - idx]; end
      MSG_REL: begin hw.to_hw_sig = 2'd2; hw.to_hw_port = msg_q[4'd15 - idx]; end
      KEY_PUT: begin hw.to_hw_sig = 2'd2; hw.to_hw_port = key_q[4'd15 - idx]; end
      KEY_REL: begin hw.to_hw_sig = 2'd1; hw.to_hw_port = key_q[4'd15 - idx]; end
      GO:      hw.to_hw_sig = 2'd3;
      RD_REQ:  hw.to_hw_sig = 2'd1;
      RD_REL:  hw.to_hw_sig = 2'd2;
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/io_host_driver.md
IO_HOST_DRIVER -- requirements
Module: io_host_driver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk` (input, 1, rising-edge clock) and `reset` (input, 1, async active-high reset).
REQ-002 `start` SHALL be an input of width 1: a one-cycle request to run one transaction.
REQ-003 `msg_in` SHALL be an input of width 128: the message to send, byte 0 = [127:120].
REQ-004 `key_in` SHALL be an input of width 128: the key to send, byte 0 = [127:120].
REQ-005 `to_hw_sig` SHALL be an output of width 2: the handshake code to the peer.
REQ-006 `to_hw_port` SHALL be an output of width 8: the data byte to the peer.
REQ-007 `to_sw_sig` SHALL be an input of width 2: the handshake code from the peer.
REQ-008 `to_sw_port` SHALL be an input of width 8: the result byte from the peer.
REQ-009 `msg_out` SHALL be an output of width 128: the result, byte 0 = [127:120].
REQ-010 `busy` SHALL be an output of width 1: high while a transaction is in progress.
REQ-011 `done` SHALL be an output of width 1: a one-cycle pulse when `msg_out` is valid.
REQ-012 `error` SHALL be an output of width 1: sticky watchdog flag (see Configuration).

Function
REQ-013 The FSM states SHALL be IDLE, MSG_PUT, MSG_REL, KEY_PUT, KEY_REL, GO, RD_REQ, RD_REL, FIN; the byte index SHALL be a 4-bit counter `idx`.
REQ-014 In IDLE with `start`=1, the block SHALL:
- register `msg_in` and `key_in`;
- set `idx`=0;
- move to MSG_PUT.

The registered copies SHALL be the only source used for the rest of the transaction.
REQ-015 The block SHALL ignore `start` in every state except IDLE.
REQ-016 MSG_PUT SHALL drive `to_hw_port`=msg byte[`idx`] and `to_hw_sig`=1, and SHALL move to MSG_REL when `to_sw_sig`==1.
REQ-017 MSG_REL SHALL hold the same byte and drive `to_hw_sig`=2. When `to_sw_sig`==0:
- if `idx`==15, it SHALL set `idx`=0 and go to KEY_PUT;
- otherwise it SHALL increment `idx` and go to MSG_PUT.
REQ-018 KEY_PUT/KEY_REL SHALL mirror MSG_PUT/MSG_REL using key bytes, with strobe code 2 and release code 1. After the byte-15 release, the FSM SHALL go to GO.
REQ-019 GO SHALL drive `to_hw_sig`=3 and `to_hw_port`=0 until `to_sw_sig`==2. It SHALL then set `idx`=0 and go to RD_REQ.
REQ-020 RD_REQ SHALL drive `to_hw_sig`=1. When `to_sw_sig`==1 it SHALL capture `to_sw_port` into `msg_out` byte[`idx`] on that same edge and go to RD_REL.
REQ-021 RD_REL SHALL drive `to_hw_sig`=2. When `to_sw_sig`==0:
- if `idx`==15, it SHALL go to FIN;
- otherwise it SHALL increment `idx` and return to RD_REQ.
REQ-022 FIN SHALL drive `to_hw_sig`=0, assert `done` for exactly one cycle, and return to IDLE.
REQ-023 In IDLE, `to_hw_sig` and `to_hw_port` SHALL be 0.
REQ-024 `busy` SHALL be 1 in every state except IDLE; it SHALL be 1 in FIN.
REQ-025 `to_hw_sig` and `to_hw_port` SHALL be decoded from the registered state and `idx` only, with no combinational path from `to_sw_sig` to them.
REQ-026 The minimum handshake latency SHALL be 1 cycle per phase edge. A peer answering in the same cycle gives 2 cycles per byte and 98 cycles from `start` to `done`.
REQ-027 `msg_out` SHALL change only in RD_REQ captures. It SHALL hold its value across IDLE, and in a new transaction until each byte is overwritten.
REQ-028 Any `to_sw_sig` value other than the one awaited SHALL leave the state unchanged (no skipping and no early advance).

Reset
REQ-029 Assertion of `reset`, including mid-transaction, SHALL asynchronously force:
- the state to IDLE;
- `idx`, `msg_out`, the registered msg/key and the watchdog count to 0;
- `to_hw_sig`, `to_hw_port`, `busy`, `done` and `error` to 0.
REQ-030 On the first clock edge after `reset` deasserts, a `start`=1 SHALL be accepted.

Configuration
REQ-031 With `IO_HOST_TIMEOUT_EN` defined, the block SHALL include a 16-bit watchdog counter:
- it SHALL clear on every state change;
- it SHALL increment on every cycle spent in a waiting state (any state except IDLE and FIN);
- when it reaches 16'hFFFF, the block SHALL set `error`=1 and go to IDLE without asserting `done`.
REQ-032 `error` SHALL clear only on `reset` or on an accepted `start`.
REQ-033 Without `IO_HOST_TIMEOUT_EN`, no watchdog logic SHALL exist, `error` SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Verification
REQ-034 Zero-latency responder, msg=128'h00112233445566778899AABBCCDDEEFF, key=128'h000102030405060708090A0B0C0D0E0F, result bytes 8'hF0..8'hFF -> responder logs 32 bytes in order; `msg_out`=128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF; `done` pulses once, 98 cycles after `start`.
REQ-035 Responder with random 0-7 cycle delays per edge -> the same captured bytes as REQ-034; `to_hw_port` is stable across every PUT/REL pair.
REQ-036 `start` pulsed again during KEY_PUT with `idx`=5 -> no effect; the transaction completes normally.
REQ-037 `reset` asserted in RD_REL with `idx`=9 -> all outputs 0 immediately, before the next edge; a new `start` produces a full correct transaction.
REQ-038 With `IO_HOST_TIMEOUT_EN`, the responder never answers in GO -> `error`=1 and IDLE after 65535 wait cycles, with no `done`; without the macro -> the FSM is still in GO after 100000 cycles and `error`=0.
